gap_penalty_unit: RTL and testbench
===================================

GAP_PENALTY_UNIT -- requirements
Module: gap_penalty_unit

Interface
REQ-001 SHALL have parameter SCORE_W, default 8: unsigned cell score width in bits.
REQ-002 SHALL have parameter GAP_OPEN, default 2: penalty for opening a gap, unsigned.
REQ-003 SHALL have parameter GAP_EXTEND, default 1: penalty for extending a gap, unsigned.
REQ-004 SHALL have parameter LEN_W, default 8: gap-length counter width in bits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the unit accepts the beat this cycle.
REQ-009 SHALL have port in_score, input, SCORE_W bits: H score of the preceding cell in the row.
REQ-010 SHALL have port in_last, input, 1 bit: this beat is the last cell of a row.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_score, output, SCORE_W bits: affine gap score E for this cell.
REQ-014 SHALL have port out_gap_len, output, LEN_W bits: current gap run length.
REQ-015 SHALL have port out_last, output, 1 bit: registered copy of in_last.

Function
REQ-016 SHALL accept an input beat when in_valid && in_ready, with in_ready = !out_valid || out_ready.
REQ-017 SHALL compute, for each accepted beat, o = sat0(in_score - GAP_OPEN) and e = sat0(E_prev - GAP_EXTEND), where sat0 clamps negative results to 0.
REQ-018 SHALL set the result to max(o, e), selecting "open" when o >= e (tie resolves to open) and "extend" otherwise.
REQ-019 SHALL set the gap length to 1 on open, to len_prev+1 on extend (saturating at 2^LEN_W-1), and to 0 whenever the result equals 0.
REQ-020 SHALL register the result, length and in_last into out_score, out_gap_len and out_last with exactly 1 cycle of latency, asserting out_valid the cycle after acceptance.
REQ-021 SHALL update E_prev and len_prev only on beat acceptance; they SHALL hold while stalled.
REQ-022 SHALL treat the first beat after reset, and the first beat after an accepted in_last, as row start, using E_prev = 0 and len_prev = 0.
REQ-023 SHALL keep out_score, out_gap_len and out_last stable while out_valid && !out_ready.
REQ-024 SHALL sustain one beat per cycle when out_ready is held high, with input and output acceptance allowed in the same cycle.
REQ-025 SHALL deassert out_valid after an output is accepted when no new beat is accepted in the same cycle.
REQ-026 SHALL require GAP_EXTEND <= GAP_OPEN < 2^SCORE_W, enforced by an elaboration-time check.

Reset
REQ-027 SHALL, while rst_n is low, force out_valid=0, out_score=0, out_gap_len=0, out_last=0, E_prev=0, len_prev=0 and row-start=1, regardless of clk.
REQ-028 SHALL discard any in-flight result when reset is asserted mid-row, and SHALL treat the next accepted beat as row start.

Configuration
REQ-029 SHALL, when GAP_LEN_TRACK_EN is defined, implement the gap-length counter as specified in REQ-019.
REQ-030 SHALL, when GAP_LEN_TRACK_EN is undefined, omit the counter logic, keep the out_gap_len port, and drive it with constant 0; all other behaviour SHALL be unchanged.

Structure
REQ-031 SHALL take score and length typedefs and the sat0 helper constants from the shared package gap_pkg.
REQ-032 SHALL instantiate sub-module gap_sat_sub (SCORE_W-wide saturating subtract clamping at 0) twice: once for the open candidate and once for the extend candidate.

Verification (SCORE_W=8, GAP_OPEN=2, GAP_EXTEND=1, macro defined)
REQ-033 SHALL cover a row of in_score 10,0,0,0 with in_last on the 4th beat, requiring outputs (score, len) = (8,1), (7,2), (6,3), (5,4) and out_last on the 4th output.
REQ-034 SHALL cover in_score=1 at row start, requiring out_score=0 and out_gap_len=0.
REQ-035 SHALL cover a tie case, E_prev=8 then in_score=9, requiring out_score=7 and out_gap_len=1.
REQ-036 SHALL cover out_ready low for 3 cycles while out_valid is high, requiring out_score to stay constant, in_ready=0, and no state change, followed by normal resumption.
REQ-037 SHALL cover an accepted in_last beat with E=8 followed by in_score=0, requiring out_score=0 and out_gap_len=0 (no carry-over across rows).
REQ-038 SHALL cover rst_n pulsed low mid-row, requiring all outputs 0 asynchronously and the next beat with in_score=5 to give (3,1).

Source files
------------

// File: rtl/gap_pkg.sv
// Shared types and constants for the affine gap-penalty datapath.
// Build option: define GAP_LEN_TRACK_EN to enable gap-run length tracking.
package gap_pkg;

    localparam int unsigned SCORE_W_DEF = 8;
    localparam int unsigned LEN_W_DEF   = 8;

    typedef logic [SCORE_W_DEF-1:0] score_t;
    typedef logic [LEN_W_DEF-1:0]   len_t;

    // Floor value a saturating subtract clamps to.
    localparam int unsigned SAT0_FLOOR = 0;

    typedef enum logic {
        SEL_OPEN   = 1'b0,
        SEL_EXTEND = 1'b1
    } gap_sel_e;

endpackage

// File: rtl/gap_sat_sub.sv
// Unsigned W-bit subtract that clamps negative results to zero.
module gap_sat_sub
    import gap_pkg::*;
#(
    parameter int unsigned W = SCORE_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = (a >= b) ? (a - b) : W'(SAT0_FLOOR);

endmodule

// File: rtl/gap_penalty_unit.sv
// Streaming affine gap score unit: E = max(sat0(H-open), sat0(E_prev-extend)), one beat/cycle.
// Build option: define GAP_LEN_TRACK_EN to drive out_gap_len with the live gap-run length.
module gap_penalty_unit
    import gap_pkg::*;
#(
    parameter int unsigned SCORE_W    = SCORE_W_DEF,
    parameter int unsigned GAP_OPEN   = 2,
    parameter int unsigned GAP_EXTEND = 1,
    parameter int unsigned LEN_W      = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_score,
    output logic [LEN_W-1:0]   out_gap_len,
    output logic               out_last
);

    if (!((GAP_EXTEND <= GAP_OPEN) && (64'(GAP_OPEN) < (64'd1 << SCORE_W)))) begin : g_param_check
        $error("gap_penalty_unit: need GAP_EXTEND <= GAP_OPEN < 2**SCORE_W");
    end

    logic               out_valid_q, out_last_q, row_start_q;
    logic [SCORE_W-1:0] out_score_q, e_prev_q;
    logic [SCORE_W-1:0] e_prev_eff, open_cand, ext_cand, result_d;
    gap_sel_e           sel_d;
    logic               accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A row start behaves as if the previous E were zero.
    assign e_prev_eff = row_start_q ? '0 : e_prev_q;

    gap_sat_sub #(.W(SCORE_W)) u_open (
        .a (in_score),
        .b (SCORE_W'(GAP_OPEN)),
        .y (open_cand)
    );

    gap_sat_sub #(.W(SCORE_W)) u_extend (
        .a (e_prev_eff),
        .b (SCORE_W'(GAP_EXTEND)),
        .y (ext_cand)
    );

    // Ties go to opening a fresh gap.
    assign sel_d    = (open_cand >= ext_cand) ? SEL_OPEN : SEL_EXTEND;
    assign result_d = (sel_d == SEL_OPEN) ? open_cand : ext_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_score_q <= '0;
            out_last_q  <= 1'b0;
            e_prev_q    <= '0;
            row_start_q <= 1'b1;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_score_q <= result_d;
            out_last_q  <= in_last;
            e_prev_q    <= result_d;
            row_start_q <= in_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef GAP_LEN_TRACK_EN
    logic [LEN_W-1:0] len_prev_q, out_len_q, len_prev_eff, len_d;

    assign len_prev_eff = row_start_q ? '0 : len_prev_q;

    always_comb begin
        len_d = '0;
        if (result_d == '0) begin
            len_d = '0;
        end else if (sel_d == SEL_OPEN) begin
            len_d = LEN_W'(1);
        end else if (len_prev_eff == '1) begin
            len_d = '1;
        end else begin
            len_d = len_prev_eff + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_prev_q <= '0;
            out_len_q  <= '0;
        end else if (accept) begin
            len_prev_q <= len_d;
            out_len_q  <= len_d;
        end
    end

    assign out_gap_len = out_len_q;
`else
    assign out_gap_len = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_score = out_score_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_gap_penalty_unit.sv
// Directed plus randomized bench for gap_penalty_unit against an arithmetic reference model.
module tb_gap_penalty_unit;

    localparam int SW      = 8;
    localparam int GO      = 2;
    localparam int GE      = 1;
    localparam int LW      = 8;
    localparam int LEN_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_score = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] out_score;
    logic [LW-1:0] out_gap_len;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    // Reference state: row-level E/len plus the expected output register contents.
    int m_e, m_len;
    bit m_row_start;
    bit exp_valid;
    int exp_score, exp_len;
    bit exp_last;

    gap_penalty_unit #(
        .SCORE_W(SW), .GAP_OPEN(GO), .GAP_EXTEND(GE), .LEN_W(LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_score   (in_score),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_score  (out_score),
        .out_gap_len(out_gap_len),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_len = 0; m_row_start = 1;
        exp_valid = 0; exp_score = 0; exp_len = 0; exp_last = 0;
    endtask

    task automatic model_step(input int s, input bit last);
        int ep, lp, o, e, r, l;
        ep = m_row_start ? 0 : m_e;
        lp = m_row_start ? 0 : m_len;
        o = (s - GO > 0) ? s - GO : 0;
        e = (ep - GE > 0) ? ep - GE : 0;
        if (o >= e) begin
            r = o; l = 1;
        end else begin
            r = e; l = (lp + 1 > LEN_MAX) ? LEN_MAX : lp + 1;
        end
        if (r == 0) l = 0;
        m_e = r; m_len = l; m_row_start = last;
        exp_valid = 1; exp_score = r; exp_last = last;
`ifdef GAP_LEN_TRACK_EN
        exp_len = l;
`else
        exp_len = 0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
            chk({tag, ".score"}, int'(out_score), exp_score);
            chk({tag, ".len"}, int'(out_gap_len), exp_len);
            chk({tag, ".last"}, int'(out_last), int'(exp_last));
        end
    endtask

    // One clock cycle: drive on negedge, check in_ready, then check registered outputs after posedge.
    task automatic cycle(input string tag, input bit v, input int s, input bit last, input bit rdy);
        bit acc;
        @(negedge clk);
        in_valid = v; in_score = SW'(s); in_last = last; out_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, int'(in_ready), int'(!exp_valid || rdy));
        acc = v && (!exp_valid || rdy);
        @(posedge clk);
        #1;
        if (acc) model_step(s, last);
        else if (rdy) exp_valid = 0;
        check_outputs(tag);
        $display("[%0t] %s v=%0b s=%0d last=%0b rdy=%0b acc=%0b -> out v=%0b score=%0d len=%0d last=%0b",
                 $time, tag, v, s, last, rdy, acc, out_valid, out_score, out_gap_len, out_last);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".score"}, int'(out_score), 0);
        chk({tag, ".len"}, int'(out_gap_len), 0);
        chk({tag, ".last"}, int'(out_last), 0);
        @(negedge clk);
        rst_n = 1;
        $display("[%0t] %s asynchronous reset pulse", $time, tag);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.score", int'(out_score), 0);
        chk("rst.len", int'(out_gap_len), 0);
        chk("rst.last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1;

        // Row 10,0,0,0: (8,1) (7,2) (6,3) (5,4), last on the 4th.
        cycle("row_a0", 1, 10, 0, 1);
        cycle("row_a1", 1, 0, 0, 1);
        cycle("row_a2", 1, 0, 0, 1);
        cycle("row_a3", 1, 0, 1, 1);
        cycle("drain", 0, 0, 0, 1);

        // Small score at row start clamps to zero.
        cycle("low_start", 1, 1, 1, 1);

        // Tie: E_prev=8, then H=9 gives 7 by opening.
        cycle("tie0", 1, 10, 0, 1);
        cycle("tie1", 1, 9, 0, 1);

        // Stall three cycles with a beat waiting, then resume.
        cycle("stall_pre", 1, 50, 0, 0);
        for (int i = 0; i < 3; i++) cycle("stall", 1, 200, 0, 0);
        cycle("resume", 1, 3, 1, 1);
        cycle("idle", 0, 0, 0, 1);

        // No carry-over across rows: E=8 on an in_last beat, then 0.
        cycle("row_end", 1, 10, 1, 1);
        cycle("new_row", 1, 0, 0, 1);

        // Reset mid-row, then 5 gives (3,1).
        cycle("pre_rst", 1, 40, 0, 1);
        async_reset("midrst");
        cycle("post_rst", 1, 5, 0, 1);

        // Long extend run with len well past the open point.
        cycle("run0", 1, 255, 0, 1);
        for (int i = 0; i < 20; i++) cycle("run", 1, 0, 0, 1);
        cycle("run_end", 1, 0, 1, 1);

        // Randomized traffic with random stalls and row boundaries.
        for (int i = 0; i < 300; i++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            cycle("rand", bit'($urandom_range(0, 3) != 0), s,
                  bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) != 0));
        end
        cycle("final", 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
